// File: rtl/instr_fetch_queue.sv
// First-word-fall-through queue of {pc, instr} pairs between fetch and decode.
// A taken-branch redirect (flush_F) empties the queue without clearing storage.
module instr_fetch_queue #(
   parameter int N     = 64,
   parameter int IW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush_F,
   input  logic                       push_F,
   input  logic [N-1:0]               pc_F,
   input  logic [IW-1:0]              instr_F,
   output logic                       ready_F,
   input  logic                       ready_D,
   output logic                       valid_D,
   output logic [N-1:0]               pc_D,
   output logic [IW-1:0]              instr_D,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [N-1:0]  r_pc_mem    [DEPTH];
   logic [IW-1:0] r_instr_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic w_push;
   logic w_pop;

   // ready_F uses registered count only: a full queue refuses a push even when decode pops
   assign ready_F = (r_count != CW'(DEPTH));
   assign valid_D = (r_count != '0);
   assign count   = r_count;

   assign w_push = push_F && ready_F && !flush_F;
   assign w_pop  = ready_D && valid_D && !flush_F;

   assign pc_D    = valid_D ? r_pc_mem[r_rd_ptr]    : '0;
   assign instr_D = valid_D ? r_instr_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= pc_F;
         r_instr_mem[r_wr_ptr] <= instr_F;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush_F) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: stimulus queues expected head entries,
// a negedge monitor compares every accepted pop against them.
module tb_instr_fetch_queue;

   localparam int N     = 64;
   localparam int IW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush_F;
   logic          push_F;
   logic [N-1:0]  pc_F;
   logic [IW-1:0] instr_F;
   logic          ready_F;
   logic          ready_D;
   logic          valid_D;
   logic [N-1:0]  pc_D;
   logic [IW-1:0] instr_D;
   logic [2:0]    count;

   typedef struct packed {
      logic [N-1:0]  pc;
      logic [IW-1:0] ins;
   } ent_t;

   ent_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   m_count = 0;

   instr_fetch_queue #(.N(N), .IW(IW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .flush_F (flush_F),
      .push_F  (push_F),
      .pc_F    (pc_F),
      .instr_F (instr_F),
      .ready_F (ready_F),
      .ready_D (ready_D),
      .valid_D (valid_D),
      .pc_D    (pc_D),
      .instr_D (instr_D),
      .count   (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: a pop is accepted at the coming edge, so the head must match the oldest expected entry
   always @(negedge clk) begin
      if (reset === 1'b0 && ready_D && valid_D && !flush_F) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected: got pc 0x%0h expected no valid head", pc_D);
         end else begin
            ent_t e;
            e = exp_q.pop_front();
            if (pc_D !== e.pc || instr_D !== e.ins) begin
               n_err++;
               $display("FAIL pop_data: got pc 0x%0h instr 0x%0h expected pc 0x%0h instr 0x%0h",
                        pc_D, instr_D, e.pc, e.ins);
            end
         end
      end
   end

   task automatic step(input logic p, input logic [N-1:0] pc, input logic [IW-1:0] ins,
                       input logic rd, input logic fl);
      logic pa, pp;
      push_F  = p;
      pc_F    = pc;
      instr_F = ins;
      ready_D = rd;
      flush_F = fl;
      pa = p && (m_count != DEPTH) && !fl;
      pp = rd && (m_count != 0) && !fl;
      @(posedge clk);
      #1;
      if (fl) begin
         exp_q.delete();
         m_count = 0;
      end else begin
         if (pa) exp_q.push_back({pc, ins});
         m_count = m_count + int'(pa) - int'(pp);
      end
      chk("count", 64'(count), 64'(m_count));
      chk("valid_D", 64'(valid_D), 64'(m_count != 0));
      chk("ready_F", 64'(ready_F), 64'(m_count != DEPTH));
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; flush_F = 1'b0; push_F = 1'b1; pc_F = 64'h4; instr_F = 32'hDEAD;
      ready_D = 1'b0;
      // reset held for two cycles with a push pending
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(valid_D), 64'd0);
      chk("rst_pc", pc_D, 64'd0);
      chk("rst_instr", 64'(instr_D), 64'd0);
      chk("rst_ready", 64'(ready_F), 64'd1);
      reset = 1'b0;
      push_F = 1'b0;

      // fill, overflow push dropped, drain
      for (int i = 0; i < 4; i++) step(1'b1, 64'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
      chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(ready_F), 64'd0);
      step(1'b1, 64'h10, 32'hA4, 1'b0, 1'b0);
      chk("full_drop_count", 64'(count), 64'd4);
      chk("full_head", pc_D, 64'h0);
      // push offered while full and popping: still refused
      step(1'b1, 64'h14, 32'hA5, 1'b1, 1'b0);
      chk("full_pop_push_count", 64'(count), 64'd3);
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("drain_valid", 64'(valid_D), 64'd0);
      chk("drain_pc", pc_D, 64'd0);
      chk("drain_instr", 64'(instr_D), 64'd0);

      // steady state at count = 2
      step(1'b1, 64'h1000, 32'hB000, 1'b0, 1'b0);
      chk("latency_head", pc_D, 64'h1000);
      step(1'b1, 64'h1004, 32'hB004, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 64'h20 + 64'(4 * i), 32'hC000 + 32'(i), 1'b1, 1'b0);
         chk("steady_count", 64'(count), 64'd2);
      end
      step(1'b0, '0, '0, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // interleaved pushes and pops so both pointers wrap more than once
      for (int i = 0; i < 12; i++) begin
         logic p, r;
         p = (i % 3) != 2;
         r = (i % 2) == 1;
         step(p, 64'h300 + 64'(8 * i), 32'hE000 + 32'(i), r, 1'b0);
      end
      while (m_count != 0) step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("wrap_empty", 64'(count), 64'd0);

      // flush with simultaneous push and pop
      for (int i = 0; i < 3; i++) step(1'b1, 64'h50 + 64'(4 * i), 32'hF0 + 32'(i), 1'b0, 1'b0);
      chk("pre_flush_count", 64'(count), 64'd3);
      step(1'b1, 64'h40, 32'h40, 1'b1, 1'b1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(valid_D), 64'd0);
      chk("flush_ready", 64'(ready_F), 64'd1);
      step(1'b1, 64'h100, 32'h1100, 1'b0, 1'b0);
      chk("redirect_head_pc", pc_D, 64'h100);
      chk("redirect_head_instr", 64'(instr_D), 64'h1100);
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // pops on an empty queue
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("empty_pop_count", 64'(count), 64'd0);
      step(1'b1, 64'h200, 32'h2200, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // reset mid-operation
      step(1'b1, 64'h600, 32'h6600, 1'b0, 1'b0);
      step(1'b1, 64'h604, 32'h6604, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      m_count = 0;
      chk("midrst_count", 64'(count), 64'd0);
      chk("midrst_pc", pc_D, 64'd0);
      step(1'b1, 64'h700, 32'h7700, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      idle();

      chk("scoreboard_left", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
